// File: rtl/led_test_pkg.sv
// Shared timing constants and sequencer state type for the everloop
// LED ring test-pattern generator (led_test, led_bit_tx).
package led_test_pkg;

    localparam int BIT_CYCLES   = 63;
    localparam int T0H          = 20;
    localparam int T1H          = 40;
    localparam int LATCH_CYCLES = 4000;
    localparam int BITS_PER_LED = 32;

    localparam int BIT_CW   = $clog2(BIT_CYCLES);
    localparam int LATCH_CW = $clog2(LATCH_CYCLES);
    localparam int BIT_IW   = $clog2(BITS_PER_LED);

    typedef enum logic [1:0] {
        ST_LATCH,
        ST_LOAD,
        ST_SEND
    } state_t;

endpackage

// File: rtl/led_bit_tx.sv
// NRZ single-bit serializer: start loads bit_val, dout high T0H/T1H
// clocks then low, done pulses on the last of BIT_CYCLES clocks.
// Ports: clk, rst (async active-low), start, bit_val, dout, done.
module led_bit_tx (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic done
);
    import led_test_pkg::*;

    localparam logic [BIT_CW-1:0] LAST = BIT_CW'(BIT_CYCLES - 1);
    localparam logic [BIT_CW-1:0] HI0  = BIT_CW'(T0H);
    localparam logic [BIT_CW-1:0] HI1  = BIT_CW'(T1H);

    logic [BIT_CW-1:0] cnt;
    logic [BIT_CW-1:0] nxt;
    logic [BIT_CW-1:0] hi_len;
    logic              busy;
    logic              hi;

    assign nxt    = cnt + 1'b1;
    assign hi_len = hi ? HI1 : HI0;
    assign done   = busy && (cnt == LAST);

    // A start on the done cycle begins the next bit with no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi   <= 1'b0;
            dout <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            hi   <= bit_val;
            dout <= 1'b1;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
                dout <= 1'b0;
            end else begin
                cnt  <= nxt;
                dout <= (nxt < hi_len);
            end
        end
    end

endmodule

// File: rtl/led_test.sv
// Everloop ring test pattern: one LED lit with LIT_COLOR at index pos,
// streamed as NUM_LEDS GRBW words MSB first, then a latch gap.
// Ports: clk, rst (async active-low), led_ctl (NRZ data, registered).
// Macro LED_TEST_FAST_SIM_EN: pos advances every frame, not every
// STEP_FRAMES frames; bit and latch timing unchanged.
module led_test #(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          NUM_LEDS    = 35,
    parameter logic [31:0] LIT_COLOR   = 32'h0040_0000,
    parameter int          STEP_FRAMES = 67
) (
    input  logic clk,
    input  logic rst,
    output logic led_ctl
);
    import led_test_pkg::*;

`ifdef LED_TEST_FAST_SIM_EN
    localparam int STEP = 1;
`else
    localparam int STEP = STEP_FRAMES;
`endif

    if (CLK_FREQ_HZ <= 0 || NUM_LEDS < 1 || STEP_FRAMES < 1) begin : g_bad_cfg
        $error("led_test: invalid parameters");
    end

    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int FW = $clog2(STEP + 1);

    localparam logic [LW-1:0]       LAST_LED  = LW'(NUM_LEDS - 1);
    localparam logic [BIT_IW-1:0]   MSB_BIT   = BIT_IW'(BITS_PER_LED - 1);
    localparam logic [LATCH_CW-1:0] LATCH_END = LATCH_CW'(LATCH_CYCLES - 1);
    localparam logic [FW-1:0]       STEP_END  = FW'(STEP);

    state_t              state;
    logic [LATCH_CW-1:0] latch_cnt;
    logic [LW-1:0]       led_idx;
    logic [LW-1:0]       nled;
    logic [LW-1:0]       pos;
    logic [LW-1:0]       npos;
    logic [LW-1:0]       sel_pos;
    logic [BIT_IW-1:0]   bit_idx;
    logic [BIT_IW-1:0]   nbit;
    logic [FW-1:0]       frame_cnt;
    logic                latch_end;
    logic                step;
    logic                last_bit;
    logic                last_led;
    logic                start;
    logic                tx_bit;
    logic                bit_done;

    assign latch_end = (state == ST_LATCH) && (latch_cnt == LATCH_END);
    assign step      = (frame_cnt == STEP_END);
    assign last_bit  = (bit_idx == '0);
    assign last_led  = (led_idx == LAST_LED);
    assign npos      = !step ? pos
                     : (pos == LAST_LED) ? '0 : pos + 1'b1;

    // The first bit of a frame is issued on the same edge that takes
    // the new pos, so it must see the advanced position already.
    assign sel_pos = (state == ST_LATCH) ? npos : pos;
    assign tx_bit  = (nled == sel_pos) && LIT_COLOR[nbit];

    // Next word/bit select is precomputed so LOAD costs no cycles.
    always_comb begin
        start = 1'b0;
        nled  = led_idx;
        nbit  = bit_idx;
        unique case (1'b1)
            latch_end: begin
                start = 1'b1;
                nled  = '0;
                nbit  = MSB_BIT;
            end
            bit_done && !last_bit: begin
                start = 1'b1;
                nbit  = bit_idx - 1'b1;
            end
            bit_done && last_bit && !last_led: begin
                start = 1'b1;
                nled  = led_idx + 1'b1;
                nbit  = MSB_BIT;
            end
            default: ;
        endcase
    end

    // LOAD marks the first bit of each word, SEND the remaining bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LATCH;
            latch_cnt <= '0;
            led_idx   <= '0;
            bit_idx   <= '0;
            pos       <= '0;
            frame_cnt <= '0;
        end else begin
            unique case (state)
                ST_LATCH: begin
                    if (latch_end) begin
                        state     <= ST_LOAD;
                        latch_cnt <= '0;
                        pos       <= npos;
                        if (step) frame_cnt <= '0;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                ST_LOAD, ST_SEND: begin
                    if (bit_done) begin
                        if (!last_bit) begin
                            state <= ST_SEND;
                        end else if (!last_led) begin
                            state <= ST_LOAD;
                        end else begin
                            state     <= ST_LATCH;
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_LATCH;
            endcase
            led_idx <= nled;
            bit_idx <= nbit;
        end
    end

    led_bit_tx u_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bit_val (tx_bit),
        .dout    (led_ctl),
        .done    (bit_done)
    );

endmodule

// File: tb/tb_led_test.sv
// Testbench for led_test: per-cycle waveform against an arithmetic
// reference, pulse widths/spacing, frame period, position stepping.
module tb_led_test;

    localparam int NLED  = 2;
    localparam int STEPF = 2;
    localparam int BITC  = 63;
    localparam int T0    = 20;
    localparam int T1    = 40;
    localparam int LATCH = 4000;
    localparam int BITS  = NLED * 32;
    localparam int FR    = BITS * BITC + LATCH;
    localparam logic [31:0] COLOR = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic led_ctl;

    led_test #(
        .CLK_FREQ_HZ (50_000_000),
        .NUM_LEDS    (NLED),
        .LIT_COLOR   (COLOR),
        .STEP_FRAMES (STEPF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_ctl (led_ctl)
    );

    always #5 clk = ~clk;

    int   total  = 0;
    int   passed = 0;
    int   t;
    int   mism;
    int   bad_t;
    logic prev;
    int   rises[$];
    int   widths[$];

    // Expected level after the tt-th rising edge following release.
    function automatic logic model(input int tt);
        int   u, f, r, bp, led, b, p;
        logic v;
        if (tt < LATCH) return 1'b0;
        u = tt - LATCH;
        f = u / FR;
        r = u % FR;
        if (r >= BITS * BITC) return 1'b0;
        bp  = r / BITC;
        led = bp / 32;
        b   = 31 - (bp % 32);
        p   = (f / STEPF) % NLED;
        v   = (led == p) ? COLOR[b] : 1'b0;
        return (r % BITC) < (v ? T1 : T0);
    endfunction

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s: got %0d want %0d", tag, got, want);
    endtask

    task automatic restart();
        t    = 0;
        mism = 0;
        bad_t = -1;
        prev = 1'b0;
        rises.delete();
        widths.delete();
    endtask

    task automatic run_to(input int last);
        logic lvl;
        while (t < last) begin
            @(posedge clk);
            t++;
            #1;
            lvl = led_ctl;
            if (lvl !== model(t)) begin
                if (mism == 0) bad_t = t;
                mism++;
            end
            if (lvl && !prev) rises.push_back(t);
            if (!lvl && prev && rises.size() > 0)
                widths.push_back(t - rises[rises.size()-1]);
            prev = lvl;
        end
    endtask

    initial begin
        int rb, off, target, highs, n, cnt40, word;

        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("rst_hold", led_ctl, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        restart();

        // Abort somewhere inside the guaranteed-high part of a frame-2 bit.
        rb     = $urandom_range(0, BITS - 1);
        off    = $urandom_range(0, T0 - 1);
        target = LATCH + 2 * FR + rb * BITC + off;
        run_to(target);
        check("run1_first_bad_cycle", bad_t, -1);
        check("pre_abort_high", led_ctl, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_async", led_ctl, 0);
        highs = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (led_ctl !== 1'b0) highs++;
        end
        check("abort_hold_low", highs, 0);
        @(negedge clk);
        rst = 1'b1;
        restart();

        run_to(LATCH + 5 * FR + 1);
        check("run2_first_bad_cycle", bad_t, -1);
        check("edge_total", rises.size(), 5 * BITS + 1);
        check("first_rise", rises[0], LATCH);
        for (int i = 0; i < 8; i++)
            check("g_bit_width", widths[i], T0);
        check("r7_width", widths[8], T0);
        check("r6_width", widths[9], T1);
        check("bit_spacing", rises[1] - rises[0], BITC);
        check("bit_spacing_10", rises[9] - rises[8], BITC);
        check("word_spacing", rises[32] - rises[31], BITC);
        check("frame_period", rises[BITS] - rises[0], FR);
        check("frame_period_4", rises[5*BITS] - rises[4*BITS], FR);

        n = 0;
        foreach (rises[i])
            if (rises[i] >= LATCH && rises[i] < LATCH + FR) n++;
        check("frame0_edges", n, BITS);

        for (int k = 0; k < 5; k++) begin
            cnt40 = 0;
            word  = -1;
            for (int i = k * BITS; i < (k + 1) * BITS; i++) begin
                if (i < widths.size() && widths[i] == T1) begin
                    cnt40++;
                    word = (i - k * BITS) / 32;
                end
            end
            check("frame_wide_pulses", cnt40, 1);
            check("frame_lit_word", word, (k / STEPF) % NLED);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_test.md
LED_TEST -- requirements
Module: led_test

Interface
- REQ-001 Parameter CLK_FREQ_HZ, 50_000_000, system clock frequency; documentation only, timing constants below are in cycles.
- REQ-002 Parameter NUM_LEDS, 35, number of daisy-chained RGBW LEDs on the everloop ring.
- REQ-003 Parameter LIT_COLOR, 32'h0040_0000, {G,R,B,W} word for the lit LED (red = 0x40).
- REQ-004 Parameter STEP_FRAMES, 67, frames per position step when LED_TEST_FAST_SIM_EN is undefined (about 100 ms).
- REQ-005 Port clk, input, 1, single system clock, rising-edge active.
- REQ-006 Port rst, input, 1, asynchronous active-low reset.
- REQ-007 Port led_ctl, output, 1, single-wire NRZ data line to the first LED, registered.

Function
- REQ-008 Block SHALL be a self-contained test-pattern generator: one LED lit with LIT_COLOR at index pos, all other LEDs 32'h0.
- REQ-009 Frame SHALL be NUM_LEDS words of 32 bits each, LED 0 first, each word MSB first in G[31:24], R[23:16], B[15:8], W[7:0] order.
- REQ-010 Each bit SHALL last BIT_CYCLES = 63 clocks, with led_ctl high first.
- REQ-011 A 0-bit SHALL hold led_ctl high for T0H = 20 clocks; a 1-bit SHALL hold it high for T1H = 40 clocks; led_ctl SHALL be low for the remainder of the bit.
- REQ-012 Between frames, led_ctl SHALL be low for LATCH_CYCLES = 4000 clocks (80 us).
- REQ-013 Frame period SHALL be exactly NUM_LEDS*32*63 + 4000 = 74560 clocks, with no idle gaps between bits or words.
- REQ-014 State machine SHALL have states LATCH -> LOAD -> SEND -> LOAD (next word), and SEND -> LATCH after bit 0 of LED NUM_LEDS-1.
- REQ-015 LOAD SHALL take zero extra cycles, so the word select is precomputed and the bit timing stays seamless.
- REQ-016 pos SHALL update only at the LATCH-to-LOAD transition, so a frame never mixes two positions.
- REQ-017 pos SHALL increment after every STEP_FRAMES completed frames (every frame if the macro is defined) and wrap from NUM_LEDS-1 to 0.
- REQ-018 Counters SHALL be sized with $clog2 of their maximum value; there is no overflow beyond the stated terminal counts.

Reset
- REQ-019 While rst = 0: led_ctl = 0 immediately (asynchronously), state = LATCH, all counters = 0, pos = 0, frame counter = 0.
- REQ-020 After rst release, the first rising edge of led_ctl SHALL occur exactly 4000 clocks later, starting LED 0 with pos = 0.
- REQ-021 Reset asserted mid-frame SHALL abort the frame with no partial-bit completion and restart per REQ-020.

Configuration
- REQ-022 Macro LED_TEST_FAST_SIM_EN defined: pos advances every frame.
- REQ-023 Macro LED_TEST_FAST_SIM_EN undefined: pos advances every STEP_FRAMES frames.
- REQ-024 Bit and latch timing SHALL be identical with and without the macro.

Structure
- REQ-025 Package led_test_pkg SHALL hold BIT_CYCLES, T0H, T1H, LATCH_CYCLES, BITS_PER_LED = 32, and the state enum type.
- REQ-026 Sub-module led_bit_tx SHALL serialize one bit: inputs start and bit, outputs dout and done, with done pulsed on the last cycle of the bit.
- REQ-027 Top level led_test SHALL contain the frame/word/bit sequencer, the pattern generator and the position counter.

Verification
- REQ-028 Hold rst = 0 for 10 clocks -> led_ctl = 0 throughout; release -> led_ctl low for exactly 4000 clocks, then rises.
- REQ-029 First frame -> first 8 pulses (G = 0x00) are 20 clocks high; 9th pulse (R bit 7 = 0) is 20 clocks high; 10th pulse (R bit 6 = 1) is 40 clocks high; rising edges are 63 clocks apart.
- REQ-030 Count rising edges in one frame -> 1120; consecutive frame starts are 74560 clocks apart.
- REQ-031 With LED_TEST_FAST_SIM_EN, run 40 frames -> frame k has its single 40-clock-wide pulse pattern in word k mod 35; frame 35 returns to word 0.
- REQ-032 Without the macro -> frames 0 to 66 light LED 0 and frame 67 lights LED 1.
- REQ-033 Assert rst during a high phase in frame 2 -> led_ctl falls within the same cycle; after release, the REQ-020 behaviour repeats with pos = 0.
